// File: rtl/spi_slave.sv
// SPI mode-0 slave with clk-domain oversampling, single-entry transmit buffer and framed receive.
// Optional macro SPI_SLAVE_MISO_HIZ_EN: tri-state miso while deselected or in reset.
module spi_slave #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nx;
    logic [2:0]          sclk_sr, cs_sr;
    logic [1:0]          mosi_sr;
    logic                sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic [CNT_W-1:0]    bit_cnt;
    logic                wrap_pend;
    logic [DATA_W-1:0]   tx_shift, tx_buf;
    logic [DATA_W-2:0]   rx_shift;
    logic [DATA_W-1:0]   rx_next;
    logic                frame_load, do_shift, do_sample, abort;

    // Two synchronizer flops plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sr <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            cs_sr   <= {cs_sr[1:0], cs_n};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign mosi_s    = mosi_sr[1];
    assign rx_next   = {rx_shift, mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        frame_load = 1'b0;
        do_shift   = 1'b0;
        do_sample  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nx   = SHIFT;
                    frame_load = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end else begin
                    do_sample = sclk_rise;
                    // The fall after the last bit starts the next word instead of shifting.
                    if (sclk_fall) begin
                        if (wrap_pend) frame_load = 1'b1;
                        else           do_shift   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            wrap_pend <= 1'b0;
            tx_shift  <= '0;
            tx_buf    <= '0;
            tx_ready  <= 1'b1;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (frame_load)    tx_shift <= tx_ready ? '0 : tx_buf;
            else if (do_shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

            // A load that drains the buffer wins over a same-cycle tx_load into a full buffer.
            if (frame_load && !tx_ready) begin
                tx_ready <= 1'b1;
            end else if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end

            if (abort || frame_load) begin
                bit_cnt   <= '0;
                wrap_pend <= 1'b0;
            end else if (do_sample) begin
                rx_shift <= rx_next[DATA_W-2:0];
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt   <= '0;
                    wrap_pend <= 1'b1;
                    rx_data   <= rx_next;
                    rx_valid  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_MISO_HIZ_EN
    assign miso = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'bz;
`else
    assign miso = (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (DATA_W=8); sclk half-period is 8 clk cycles.
module tb_spi_slave;

    logic       clk, rst, sclk, cs_n, mosi, miso;
    logic [7:0] tx_data, rx_data;
    logic       tx_load, tx_ready, rx_valid;
    logic [7:0] got;
    int         total, bad, vcount;

`ifdef SPI_SLAVE_MISO_HIZ_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    spi_slave #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid === 1'b1) vcount++;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        wait_clks(1);
        tx_load = 1'b0;
    endtask

    // Clocks nbits of w (MSB first); optionally pulses tx_load during bit load_bit.
    task automatic xfer(input logic [7:0] w, input int nbits, input int load_bit,
                        input logic [7:0] load_val, output logic [7:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            if (i == load_bit) begin
                load(load_val);
                wait_clks(7);
            end else begin
                wait_clks(8);
            end
            rd = {rd[6:0], miso};
            sclk = 1'b1;
            wait_clks(8);
            sclk = 1'b0;
        end
        wait_clks(8);
    endtask

    initial begin
        total = 0; bad = 0; vcount = 0;
        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_load = 1'b0;
        wait_clks(3);
        chk("rst_rx_data",  {24'b0, rx_data}, 32'h0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'h1);
        chk("rst_miso",     {31'b0, miso}, {31'b0, MISO_IDLE});
        rst = 1'b1;
        wait_clks(4);

        // Single frame: A5 out, 3C in
        load(8'hA5);
        chk("t1_ready_low", {31'b0, tx_ready}, 32'h0);
        cs_n = 1'b0;
        wait_clks(8);
        chk("t1_ready_high", {31'b0, tx_ready}, 32'h1);
        xfer(8'h3C, 8, -1, 8'h00, got);
        chk("t1_miso", {24'b0, got}, 32'hA5);
        chk("t1_rx",   {24'b0, rx_data}, 32'h3C);
        chk("t1_vcnt", vcount, 32'd1);
        cs_n = 1'b1;
        wait_clks(8);
        chk("t1_miso_idle", {31'b0, miso}, {31'b0, MISO_IDLE});

        // Back-to-back frames, 5A loaded during the first
        cs_n = 1'b0;
        wait_clks(8);
        xfer(8'h01, 8, 3, 8'h5A, got);
        chk("t2_miso0", {24'b0, got}, 32'h00);
        chk("t2_rx0",   {24'b0, rx_data}, 32'h01);
        chk("t2_vcnt0", vcount, 32'd2);
        chk("t2_ready", {31'b0, tx_ready}, 32'h1);
        xfer(8'hFF, 8, -1, 8'h00, got);
        chk("t2_miso1", {24'b0, got}, 32'h5A);
        chk("t2_rx1",   {24'b0, rx_data}, 32'hFF);
        chk("t2_vcnt1", vcount, 32'd3);
        cs_n = 1'b1;
        wait_clks(8);

        // Abort after 5 bits, then a clean frame
        cs_n = 1'b0;
        wait_clks(8);
        xfer(8'hAA, 5, -1, 8'h00, got);
        cs_n = 1'b1;
        wait_clks(8);
        chk("t3_rx_kept", {24'b0, rx_data}, 32'hFF);
        chk("t3_vcnt",    vcount, 32'd3);
        cs_n = 1'b0;
        wait_clks(8);
        xfer(8'h81, 8, -1, 8'h00, got);
        chk("t3_rx",   {24'b0, rx_data}, 32'h81);
        chk("t3_vcnt2", vcount, 32'd4);
        chk("t3_miso", {24'b0, got}, 32'h00);
        cs_n = 1'b1;
        wait_clks(8);

        // Second load into a full buffer is ignored
        load(8'h11);
        load(8'h22);
        chk("t4_ready", {31'b0, tx_ready}, 32'h0);
        cs_n = 1'b0;
        wait_clks(8);
        xfer(8'h00, 8, -1, 8'h00, got);
        chk("t4_miso", {24'b0, got}, 32'h11);
        chk("t4_rx",   {24'b0, rx_data}, 32'h00);
        cs_n = 1'b1;
        wait_clks(8);
        chk("t4_ready_end", {31'b0, tx_ready}, 32'h1);

        // Reset mid-frame, then a fresh frame
        cs_n = 1'b0;
        wait_clks(8);
        load(8'h77);
        xfer(8'hF0, 3, -1, 8'h00, got);
        rst = 1'b0;
        cs_n = 1'b1;
        wait_clks(2);
        chk("t5_rx",    {24'b0, rx_data}, 32'h0);
        chk("t5_valid", {31'b0, rx_valid}, 32'h0);
        chk("t5_ready", {31'b0, tx_ready}, 32'h1);
        chk("t5_miso",  {31'b0, miso}, {31'b0, MISO_IDLE});
        rst = 1'b1;
        wait_clks(4);
        cs_n = 1'b0;
        wait_clks(8);
        xfer(8'hC3, 8, -1, 8'h00, got);
        chk("t5_rx2",   {24'b0, rx_data}, 32'hC3);
        chk("t5_miso2", {24'b0, got}, 32'h00);
        chk("t5_vcnt",  vcount, 32'd6);
        cs_n = 1'b1;
        wait_clks(8);
        chk("t5_miso_idle", {31'b0, miso}, {31'b0, MISO_IDLE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
